sdram_read: RTL and testbench

- Read-side SDRAM command engine: pulls 256-word blocks (64 bursts of length 4) out of SDRAM into the read FIFO.
- Sits under the shared SDRAM arbiter with the same command and handshake conventions as the write engine; the arbiter grants bus ownership and muxes rd_cmd/rd_addr/rd_bank onto the device pins.
- Advances through a frame area row by row (two half-row blocks per row), wrapping at ROW_MAX and toggling bank for ping-pong frame buffering.

---
 rtl/sdram_read.sv | 197 +++++++++++++++++++
 tb/tb_sdram_read.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read.sv
// Read-side SDRAM command engine: fetches 256-word blocks (64 bursts of 4) into the
// read FIFO, walking the frame area row by row with bank ping-pong on wrap.
module sdram_read #(
   parameter int CAS_LAT = 3,
   parameter int ROW_MAX = 1440
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_trig,
   input  logic        flag_wr,
   input  logic        rd_en,
   input  logic        aref_req,
   output logic        rd_req,
   output logic        flag_rd,
   output logic [3:0]  rd_cmd,
   output logic [12:0] rd_addr,
   output logic [1:0]  rd_bank,
   input  logic [15:0] sdram_dq_in,
   output logic        rfifo_wr_en,
   output logic [15:0] rfifo_wr_data,
   output logic        rd_flag_aref,
   output logic        flag_rd_end,
   output logic [4:0]  dbg_state_o
);

   localparam logic [4:0] S_IDLE = 5'b00001;
   localparam logic [4:0] S_REQ  = 5'b00010;
   localparam logic [4:0] S_ACT  = 5'b00100;
   localparam logic [4:0] S_RD   = 5'b01000;
   localparam logic [4:0] S_PRE  = 5'b10000;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   localparam int PW = CAS_LAT + 3;

   logic [4:0]    state_q, state_d;
   logic          rd_req_q, rd_req_d;
   logic          flag_rd_q, flag_rd_d;
   logic [3:0]    rd_cmd_q, rd_cmd_d;
   logic [12:0]   rd_addr_q, rd_addr_d;
   logic [1:0]    rd_bank_q, rd_bank_d;
   logic [1:0]    act_cnt_q, act_cnt_d;
   logic [1:0]    burst_cnt_q, burst_cnt_d;
   logic [9:0]    col_q, col_d;
   logic [12:0]   row_q, row_d;
   logic          blk_done_q, blk_done_d;
   logic [PW-1:0] pipe_q, pipe_d;
   logic          wr_en_q, wr_en_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic          aref_flag_q, aref_flag_d;
   logic          end_q, end_d;
   logic [7:0]    wr_cnt_q, wr_cnt_d;

   logic [9:0]    col_nxt;
   logic          sample_en;

   assign col_nxt   = col_q + 10'd4;
   // Burst words land CAS_LAT..CAS_LAT+3 cycles after the RD command is on the pins.
   assign sample_en = |pipe_q[CAS_LAT+2:CAS_LAT-1];

   always_comb begin
      state_d     = state_q;
      rd_req_d    = rd_req_q;
      flag_rd_d   = flag_rd_q;
      rd_cmd_d    = CMD_NOP;
      rd_addr_d   = rd_addr_q;
      rd_bank_d   = rd_bank_q;
      act_cnt_d   = 2'd0;
      burst_cnt_d = 2'd0;
      col_d       = col_q;
      row_d       = row_q;
      blk_done_d  = blk_done_q;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      aref_flag_d = (rd_cmd_q == CMD_PRE) && aref_req;
      end_d       = wr_en_q && (wr_cnt_q == 8'hFF);
      wr_cnt_d    = wr_cnt_q + {7'd0, wr_en_q};
      pipe_d      = {pipe_q[PW-2:0], (rd_cmd_q == CMD_RD)};

      case (state_q)
         S_IDLE: begin
            if (rd_trig && !flag_wr && !flag_rd_q) state_d = S_REQ;
         end
         S_REQ: begin
            if (rd_en) begin
               state_d  = S_ACT;
               rd_req_d = 1'b0;
            end else begin
               rd_req_d = 1'b1;
            end
         end
         S_ACT: begin
            act_cnt_d = (act_cnt_q == 2'd3) ? 2'd3 : act_cnt_q + 2'd1;
            if (act_cnt_q == 2'd1) begin
               rd_cmd_d  = CMD_ACT;
               rd_addr_d = row_q;
            end
            if (act_cnt_q == 2'd3) state_d = S_RD;
         end
         S_RD: begin
            burst_cnt_d = burst_cnt_q + 2'd1;
            if (burst_cnt_q == 2'd0) begin
               rd_cmd_d  = CMD_RD;
               rd_addr_d = {4'b0000, col_q[8:0]};
            end
            if (burst_cnt_q == 2'd3) begin
               col_d = col_nxt;
               if (col_nxt[7:0] == 8'd0) begin
                  state_d    = S_PRE;
                  blk_done_d = 1'b1;
                  if (col_nxt == 10'd512) begin
                     col_d = 10'd0;
                     if (row_q == 13'(ROW_MAX)) begin
                        row_d     = 13'd0;
                        rd_bank_d = ~rd_bank_q;
                     end else begin
                        row_d = row_q + 13'd1;
                     end
                  end
               end else if (aref_req) begin
                  state_d    = S_PRE;
                  blk_done_d = 1'b0;
               end
            end
         end
         S_PRE: begin
            rd_cmd_d  = CMD_PRE;
            rd_addr_d = 13'h0400;
            state_d   = blk_done_q ? S_IDLE : S_REQ;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_REQ && rd_en && !flag_rd_q) flag_rd_d = 1'b1;
      if (end_d) flag_rd_d = 1'b0;

      if (sample_en) begin
         wr_en_d   = 1'b1;
         wr_data_d = sdram_dq_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_req_q    <= 1'b0;
         flag_rd_q   <= 1'b0;
         rd_cmd_q    <= CMD_NOP;
         rd_addr_q   <= 13'd0;
         rd_bank_q   <= 2'b00;
         act_cnt_q   <= 2'd0;
         burst_cnt_q <= 2'd0;
         col_q       <= 10'd0;
         row_q       <= 13'd0;
         blk_done_q  <= 1'b0;
         pipe_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= 16'd0;
         aref_flag_q <= 1'b0;
         end_q       <= 1'b0;
         wr_cnt_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         rd_req_q    <= rd_req_d;
         flag_rd_q   <= flag_rd_d;
         rd_cmd_q    <= rd_cmd_d;
         rd_addr_q   <= rd_addr_d;
         rd_bank_q   <= rd_bank_d;
         act_cnt_q   <= act_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         blk_done_q  <= blk_done_d;
         pipe_q      <= pipe_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         aref_flag_q <= aref_flag_d;
         end_q       <= end_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   assign rd_req        = rd_req_q;
   assign flag_rd       = flag_rd_q;
   assign rd_cmd        = rd_cmd_q;
   assign rd_addr       = rd_addr_q;
   assign rd_bank       = rd_bank_q;
   assign rfifo_wr_en   = wr_en_q;
   assign rfifo_wr_data = wr_data_q;
   assign rd_flag_aref  = aref_flag_q;
   assign flag_rd_end   = end_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: two instances (CAS latency 3 and 2) share one stimulus stream;
// a frame-address model and a burst-timing scoreboard predict every command and FIFO word.
module tb_sdram_read;

   localparam int ROW_MAX = 1;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] PRE = 4'b0010;

   logic clk = 1'b0;
   logic rst_n = 1'b0, rd_trig = 1'b0, flag_wr = 1'b0, rd_en = 1'b0, aref_req = 1'b0;
   int   cyc = 0;
   logic [15:0] dq;

   logic        rd_req[2], flag_rd[2], wr_en[2], aref_f[2], rd_end[2];
   logic [3:0]  cmd[2];
   logic [12:0] addr[2];
   logic [1:0]  bank[2];
   logic [15:0] wdata[2];
   logic [4:0]  dbg[2];

   assign dq = cyc[15:0];

   sdram_read #(.CAS_LAT(3), .ROW_MAX(ROW_MAX)) u_cl3 (
      .clk(clk), .rst_n(rst_n), .rd_trig(rd_trig), .flag_wr(flag_wr), .rd_en(rd_en),
      .aref_req(aref_req), .rd_req(rd_req[0]), .flag_rd(flag_rd[0]), .rd_cmd(cmd[0]),
      .rd_addr(addr[0]), .rd_bank(bank[0]), .sdram_dq_in(dq), .rfifo_wr_en(wr_en[0]),
      .rfifo_wr_data(wdata[0]), .rd_flag_aref(aref_f[0]), .flag_rd_end(rd_end[0]),
      .dbg_state_o(dbg[0]));

   sdram_read #(.CAS_LAT(2), .ROW_MAX(ROW_MAX)) u_cl2 (
      .clk(clk), .rst_n(rst_n), .rd_trig(rd_trig), .flag_wr(flag_wr), .rd_en(rd_en),
      .aref_req(aref_req), .rd_req(rd_req[1]), .flag_rd(flag_rd[1]), .rd_cmd(cmd[1]),
      .rd_addr(addr[1]), .rd_bank(bank[1]), .sdram_dq_in(dq), .rfifo_wr_en(wr_en[1]),
      .rfifo_wr_data(wdata[1]), .rd_flag_aref(aref_f[1]), .flag_rd_end(rd_end[1]),
      .dbg_state_o(dbg[1]));

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_run = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // frame-address model and burst scoreboard
   int m_col = 0, m_row = 0, m_bank = 0;
   bit m_pre_due = 1'b0;
   int aref_col = -1, exp_aref_cyc = -1;
   int rd_t[$];
   int n_w[2] = '{0, 0};
   int end_due[2] = '{-1, -1};
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         case (cmd[0])
            ACT: begin
               check("act_row", 32'(addr[0]), 32'(m_row));
               check("act_bank", 32'(bank[0]), 32'(m_bank));
            end
            RD: begin
               check("rd_col", 32'(addr[0]), 32'(m_col));
               check("rd_bank", 32'(bank[0]), 32'(m_bank));
               check("rd_after_block_end", 32'(m_pre_due), 32'(0));
               rd_t.push_back(cyc);
               m_col += 4;
               if (m_col % 256 == 0) m_pre_due = 1'b1;
               if (m_col == 512) begin
                  m_col = 0;
                  if (m_row == ROW_MAX) begin
                     m_row = 0;
                     m_bank = m_bank ^ 3;
                  end else begin
                     m_row++;
                  end
               end
            end
            PRE: begin
               check("pre_addr", 32'(addr[0]), 32'h400);
               if (m_pre_due) m_pre_due = 1'b0;
               else check("pre_aref_col", 32'(m_col), aref_req ? 32'(aref_col + 4) : 32'hFFFF_FFFF);
               exp_aref_cyc = aref_req ? cyc + 1 : -1;
            end
            NOP: ;
            default: check("cmd_legal", 32'(cmd[0]), 32'(NOP));
         endcase
         if (aref_f[0] || cyc == exp_aref_cyc)
            check("aref_pulse", 32'(aref_f[0]), 32'(cyc == exp_aref_cyc));

         for (int d = 0; d < 2; d++) begin
            int  cl;
            int  s;
            bit  exp_en;
            cl = (d == 0) ? 3 : 2;
            s = 0;
            exp_en = 1'b0;
            if (n_w[d] < rd_t.size() * 4) begin
               s = rd_t[n_w[d] / 4] + cl + (n_w[d] % 4);
               exp_en = (cyc == s + 1);
            end
            if (wr_en[d] || exp_en) begin
               check((d == 0) ? "wr_en_cl3" : "wr_en_cl2", 32'(wr_en[d]), 32'(exp_en));
               if (wr_en[d] && exp_en) begin
                  check((d == 0) ? "wr_data_cl3" : "wr_data_cl2", 32'(wdata[d]), 32'(s[15:0]));
                  n_w[d]++;
                  if (n_w[d] % 256 == 0) end_due[d] = cyc + 1;
               end
            end
            if (rd_end[d] || cyc == end_due[d]) begin
               check((d == 0) ? "rd_end_cl3" : "rd_end_cl2", 32'(rd_end[d]), 32'(cyc == end_due[d]));
               if (rd_end[d]) check("flag_rd_clear", 32'(flag_rd[d]), 32'(0));
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset();
      for (int d = 0; d < 2; d++) begin
         check("rst_rd_req", 32'(rd_req[d]), 32'(0));
         check("rst_flag_rd", 32'(flag_rd[d]), 32'(0));
         check("rst_cmd", 32'(cmd[d]), 32'(NOP));
         check("rst_addr", 32'(addr[d]), 32'(0));
         check("rst_bank", 32'(bank[d]), 32'(0));
         check("rst_wr_en", 32'(wr_en[d]), 32'(0));
         check("rst_wr_data", 32'(wdata[d]), 32'(0));
         check("rst_aref", 32'(aref_f[d]), 32'(0));
         check("rst_end", 32'(rd_end[d]), 32'(0));
         check("rst_onehot", 32'($onehot(dbg[d])), 32'(1));
      end
   endtask

   task automatic run_block(input int aref_at, input bit trig);
      int gnt_wait;
      bit gnt_chk, done, aref_done, blk_pre_seen, req_after_end;
      gnt_wait = -1;
      gnt_chk = 1'b0;
      done = 1'b0;
      aref_done = 1'b0;
      blk_pre_seen = 1'b0;
      req_after_end = 1'b0;
      aref_col = aref_at;
      if (trig) begin
         rd_trig = 1'b1;
         tick();
         rd_trig = 1'b0;
      end
      for (int i = 0; i < 3000 && !done; i++) begin
         tick();
         rd_trig = 1'b0;
         if (gnt_chk) begin
            check("req_drop", 32'(rd_req[0]), 32'(0));
            check("flag_rd_set", 32'(flag_rd[0]), 32'(1));
            gnt_chk = 1'b0;
         end
         rd_en = 1'b0;
         if (aref_at >= 0 && !aref_done && cmd[0] == RD && m_col == aref_at + 4) begin
            aref_req = 1'b1;
            aref_done = 1'b1;
         end
         if (aref_req && aref_f[0]) aref_req = 1'b0;
         if (blk_pre_seen && rd_req[0]) req_after_end = 1'b1;
         // a trigger while the block is still draining must be ignored
         if (cmd[0] == PRE && m_col % 256 == 0 && !blk_pre_seen) begin
            blk_pre_seen = 1'b1;
            rd_trig = 1'b1;
         end
         if (gnt_wait > 0) gnt_wait--;
         else if (gnt_wait == 0) begin
            rd_en = 1'b1;
            gnt_chk = 1'b1;
            gnt_wait = -1;
         end else if (rd_req[0] && !aref_req && !blk_pre_seen) gnt_wait = $urandom_range(1, 3);
         if (rd_end[0]) done = 1'b1;
      end
      rd_trig = 1'b0;
      if (!done) check("block_timeout", 32'(0), 32'(1));
      repeat (3) begin
         tick();
         if (rd_req[0]) req_after_end = 1'b1;
      end
      check("trig_ignored", 32'(req_after_end), 32'(0));
   endtask

   initial begin
      int seen;
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset();
      rst_n = 1'b1;
      tick();
      chk_en = 1'b1;

      flag_wr = 1'b1;
      rd_trig = 1'b1;
      repeat (6) begin
         tick();
         check("flag_wr_blocks", 32'(rd_req[0]), 32'(0));
      end
      flag_wr = 1'b0;
      tick();
      rd_trig = 1'b0;
      check("req_lat1", 32'(rd_req[0]), 32'(0));
      tick();
      check("req_lat2", 32'(rd_req[0]), 32'(1));

      run_block(40, 1'b0);
      run_block(256 + 4 * $urandom_range(1, 60), 1'b1);
      run_block(252, 1'b1);
      run_block(256 + 4 * $urandom_range(0, 61), 1'b1);
      check("wrap_bank", 32'(bank[0]), 32'(3));
      run_block(-1, 1'b1);

      check("rd_count", 32'(rd_t.size()), 32'(5 * 64));
      check("words_cl3", 32'(n_w[0]), 32'(1280));
      check("words_cl2", 32'(n_w[1]), 32'(1280));

      rd_trig = 1'b1;
      tick();
      rd_trig = 1'b0;
      for (int i = 0; i < 200 && m_col < 16; i++) begin
         tick();
         rd_en = rd_req[0];
      end
      rd_en = 1'b0;
      if (m_col < 16) check("rst_setup_timeout", 32'(0), 32'(1));
      chk_en = 1'b0;
      rst_n = 1'b0;
      tick();
      check_reset();
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         seen = seen | int'(wr_en[0]) | int'(wr_en[1]);
      end
      check("inflight_dropped", 32'(seen), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
